// File: rtl/bg_scroll_ctrl.sv
// Vertical background scroll engine: frame-paced 9-bit scroll pointer plus name-table row refill
// from flash. Optional row-loaded interrupt is built when SCROLL_ROW_IRQ_EN is defined.
module bg_scroll_ctrl #(
  parameter int unsigned NT_ADDR_WIDTH = 9,
  parameter int unsigned ROW_WORDS     = 8,
  parameter int unsigned NT_ROWS       = 64,
  parameter int unsigned ROWS_PER_MAP  = 30
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     frame_tick,
  input  logic                     scrollEn,
  input  logic [7:0]               scrollCntMax,
  input  logic [23:0]              flashAddrStart,
  input  logic [7:0]               mapBackgroundMax,
  input  logic                     scrollPause,
  output logic [7:0]               mapBackgroundCnt,
  output logic [7:0]               mapScrollPtr,
  output logic                     scrollPtrHi,
  output logic                     scrollingFlag,
  output logic                     flash_req,
  output logic [23:0]              flash_addr,
  input  logic                     flash_ack,
  input  logic [31:0]              flash_rdata,
  output logic [NT_ADDR_WIDTH-1:0] nt_wraddr,
  output logic [31:0]              nt_wdata,
  output logic [3:0]               nt_we,
  output logic                     row_irq
);

  localparam int unsigned PtrW  = $clog2(NT_ROWS) + 3;
  localparam int unsigned WordW = $clog2(ROW_WORDS);
  localparam int unsigned RowW  = $clog2(ROWS_PER_MAP);

  typedef enum logic [1:0] {StIdle, StRun, StFetch, StEnd} state_e;

  state_e                   state_q, state_d;
  logic                     en_q;
  logic [PtrW-1:0]          ptr_q, ptr_d, ptr_dec;
  logic [7:0]               frame_q, frame_d;
  logic [RowW-1:0]          row_q, row_d;
  logic [7:0]               mbc_q, mbc_d;
  logic [23:0]              fa_q, fa_d;
  logic [WordW-1:0]         word_q, word_d;
  logic                     req_q, req_d;
  logic                     pend_q, pend_d;
  logic [3:0]               we_q, we_d;
  logic [NT_ADDR_WIDTH-1:0] wraddr_q, wraddr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic                     tick;
  logic                     wr_cycle;
  logic                     last_word;

  assign ptr_dec   = ptr_q - PtrW'(1);
  assign tick      = (frame_tick | pend_q) & ~scrollPause;
  // The cycle after an ack is the write cycle; the next-word / row-end decision is made there.
  assign wr_cycle  = (state_q == StFetch) & ~req_q & (we_q != 4'h0);
  assign last_word = (word_q == WordW'(ROW_WORDS - 1));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    frame_d  = frame_q;
    row_d    = row_q;
    mbc_d    = mbc_q;
    fa_d     = fa_q;
    word_d   = word_q;
    req_d    = req_q;
    pend_d   = pend_q;
    we_d     = 4'h0;
    wraddr_d = wraddr_q;
    wdata_d  = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (scrollEn && !en_q) begin
          ptr_d   = '0;
          frame_d = '0;
          row_d   = '0;
          mbc_d   = '0;
          fa_d    = flashAddrStart;
          word_d  = '0;
          pend_d  = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (!scrollEn) begin
          state_d = StIdle;
        end else if (tick) begin
          pend_d = 1'b0;
          if (frame_q == scrollCntMax) begin
            frame_d = '0;
            ptr_d   = ptr_dec;
            if (&ptr_dec[2:0]) begin
              word_d  = '0;
              req_d   = 1'b1;
              state_d = StFetch;
            end
          end else begin
            frame_d = frame_q + 8'd1;
          end
        end
      end
      StFetch: begin
        if (frame_tick) pend_d = 1'b1;
        if (req_q) begin
          if (flash_ack) begin
            req_d    = 1'b0;
            we_d     = 4'hf;
            wraddr_d = NT_ADDR_WIDTH'({ptr_q[PtrW-1:3], word_q});
            wdata_d  = flash_rdata;
          end
        end else if (wr_cycle) begin
          if (last_word) begin
            word_d = '0;
            fa_d   = fa_q + 24'(4 * ROW_WORDS);
            if (row_q == RowW'(ROWS_PER_MAP - 1)) begin
              row_d = '0;
              mbc_d = mbc_q + 8'd1;
            end else begin
              row_d = row_q + RowW'(1);
            end
            if (!scrollEn) begin
              state_d = StIdle;
            end else if ((row_q == RowW'(ROWS_PER_MAP - 1)) && (mbc_d == mapBackgroundMax)) begin
              state_d = StEnd;
            end else begin
              state_d = StRun;
            end
          end else if (!scrollEn) begin
            state_d = StIdle;
          end else begin
            word_d = word_q + WordW'(1);
            req_d  = 1'b1;
          end
        end
      end
      StEnd: begin
        if (!scrollEn) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      en_q     <= 1'b0;
      ptr_q    <= '0;
      frame_q  <= '0;
      row_q    <= '0;
      mbc_q    <= '0;
      fa_q     <= '0;
      word_q   <= '0;
      req_q    <= 1'b0;
      pend_q   <= 1'b0;
      we_q     <= 4'h0;
      wraddr_q <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      en_q     <= scrollEn;
      ptr_q    <= ptr_d;
      frame_q  <= frame_d;
      row_q    <= row_d;
      mbc_q    <= mbc_d;
      fa_q     <= fa_d;
      word_q   <= word_d;
      req_q    <= req_d;
      pend_q   <= pend_d;
      we_q     <= we_d;
      wraddr_q <= wraddr_d;
      wdata_q  <= wdata_d;
    end
  end

`ifdef SCROLL_ROW_IRQ_EN
  logic irq_q;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) irq_q <= 1'b0;
    else          irq_q <= wr_cycle & last_word;
  end
  assign row_irq = irq_q;
`else
  assign row_irq = 1'b0;
`endif

  assign mapBackgroundCnt = mbc_q;
  assign mapScrollPtr     = ptr_q[7:0];
  assign scrollPtrHi      = ptr_q[PtrW-1];
  assign scrollingFlag    = (state_q == StRun) || (state_q == StFetch);
  assign flash_req        = req_q;
  assign flash_addr       = fa_q + 24'({word_q, 2'b00});
  assign nt_wraddr        = wraddr_q;
  assign nt_wdata         = wdata_q;
  assign nt_we            = we_q;

endmodule
